aquila_wb_bridge: RTL and testbench

AQUILA_WB_BRIDGE -- requirements
Module: aquila_wb_bridge

---
 rtl/aquila_wb_pkg.sv | 17 +
 rtl/aquila_wb_bridge.sv | 143 ++++++++++++++
 tb/tb_aquila_wb_bridge.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aquila_wb_pkg.sv
// Shared definitions for the Aquila device-port to Wishbone B4 classic bridge.
package aquila_wb_pkg;

    // Bridge sequencing: accept a request, run one Wishbone cycle, pulse the response.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBus  = 2'd1,
        StResp = 2'd2
    } state_e;

    // Default number of Wishbone cycles waited for ack/err before forced termination.
    localparam int unsigned DefaultTimeoutCycles = 1024;

    // Top nibble of the device segment (0xC000_0000 - 0xCFFF_FFFF).
    localparam logic [3:0] DevSegment = 4'hC;

endpackage

// File: rtl/aquila_wb_bridge.sv
// Bridges the core M_DEVICE strobe/ready handshake onto a single-beat Wishbone B4
// classic master cycle, with err/timeout capture into a sticky error flag.
module aquila_wb_bridge
    import aquila_wb_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    // Core device port
    input  logic              dev_strobe_i,
    input  logic [XLEN-1:0]   dev_addr_i,
    input  logic              dev_rw_i,
    input  logic [XLEN/8-1:0] dev_byte_enable_i,
    input  logic [XLEN-1:0]   dev_data_i,
    output logic              dev_data_ready_o,
    output logic [XLEN-1:0]   dev_data_o,

    // Wishbone master
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [XLEN-1:0]   wb_adr_o,
    output logic [XLEN/8-1:0] wb_sel_o,
    output logic [XLEN-1:0]   wb_dat_o,
    input  logic [XLEN-1:0]   wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,

    // Error reporting
    output logic              bus_err_o,
    output logic [XLEN-1:0]   err_addr_o
);

    localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic                rw_q, rw_d;
    logic [XLEN/8-1:0]   be_q, be_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [XLEN-1:0]     resp_q, resp_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                bus_err_q, bus_err_d;
    logic [XLEN-1:0]     err_addr_q, err_addr_d;

    logic                in_bus;
    logic                in_resp;

    // Next-state: request latch, Wishbone termination (err > ack > timeout), response.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        resp_d     = resp_q;
        cnt_d      = cnt_q;
        bus_err_d  = bus_err_q;
        err_addr_d = err_addr_q;

        unique case (state_q)
            StIdle: begin
                if (dev_strobe_i) begin
                    addr_d  = dev_addr_i;
                    rw_d    = dev_rw_i;
                    be_d    = dev_byte_enable_i;
                    wdata_d = dev_data_i;
                    cnt_d   = '0;
                    state_d = StBus;
                end
            end
            StBus: begin
                cnt_d = cnt_q + 1'b1;
                if (wb_err_i) begin
                    resp_d     = '0;
                    bus_err_d  = 1'b1;
                    err_addr_d = addr_q;
                    state_d    = StResp;
                end else if (wb_ack_i) begin
                    resp_d  = rw_q ? '0 : wb_dat_i;
                    state_d = StResp;
                end else if (cnt_q == CntLast) begin
                    // Slave never answered: terminate exactly like an err.
                    resp_d     = '0;
                    bus_err_d  = 1'b1;
                    err_addr_d = addr_q;
                    state_d    = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, even mid-cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            resp_q     <= '0;
            cnt_q      <= '0;
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            resp_q     <= resp_d;
            cnt_q      <= cnt_d;
            bus_err_q  <= bus_err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign in_bus  = (state_q == StBus);
    assign in_resp = (state_q == StResp);

    // Outputs decode straight from flops so reset drops them without a clock edge.
    assign wb_cyc_o         = in_bus;
    assign wb_stb_o         = in_bus;
    assign wb_adr_o         = addr_q;
    assign wb_we_o          = in_bus & rw_q;
    assign wb_sel_o         = in_bus ? be_q : '0;
    assign wb_dat_o         = in_bus ? wdata_q : '0;
    assign dev_data_ready_o = in_resp;
    assign dev_data_o       = in_resp ? resp_q : '0;
    assign bus_err_o        = bus_err_q;
    assign err_addr_o       = err_addr_q;

endmodule

// File: tb/tb_aquila_wb_bridge.sv
// Self-checking bench for aquila_wb_bridge with a small Wishbone slave model.
module tb_aquila_wb_bridge;

    logic        clk_i;
    logic        rst_ni;
    logic        dev_strobe_i;
    logic [31:0] dev_addr_i;
    logic        dev_rw_i;
    logic [3:0]  dev_byte_enable_i;
    logic [31:0] dev_data_i;
    logic        dev_data_ready_o;
    logic [31:0] dev_data_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        bus_err_o;
    logic [31:0] err_addr_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];

    // Slave model controls
    bit ack_en    = 0;
    bit err_en    = 0;
    int ack_waits = 0;
    int wait_cnt  = 0;

    aquila_wb_bridge #(
        .XLEN           (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .dev_strobe_i      (dev_strobe_i),
        .dev_addr_i        (dev_addr_i),
        .dev_rw_i          (dev_rw_i),
        .dev_byte_enable_i (dev_byte_enable_i),
        .dev_data_i        (dev_data_i),
        .dev_data_ready_o  (dev_data_ready_o),
        .dev_data_o        (dev_data_o),
        .wb_cyc_o          (wb_cyc_o),
        .wb_stb_o          (wb_stb_o),
        .wb_we_o           (wb_we_o),
        .wb_adr_o          (wb_adr_o),
        .wb_sel_o          (wb_sel_o),
        .wb_dat_o          (wb_dat_o),
        .wb_dat_i          (wb_dat_i),
        .wb_ack_i          (wb_ack_i),
        .wb_err_i          (wb_err_i),
        .bus_err_o         (bus_err_o),
        .err_addr_o        (err_addr_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Slave: ack after ack_waits wait states, err immediately when enabled.
    assign wb_ack_i = ack_en && wb_cyc_o && wb_stb_o && (wait_cnt == ack_waits);
    assign wb_err_i = err_en && wb_cyc_o && wb_stb_o;

    always @(posedge clk_i) begin
        if (wb_cyc_o && !wb_ack_i && !wb_err_i) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    // Continuous output-gating checks
    always @(negedge clk_i) begin
        if (rst_ni && !dev_data_ready_o) begin
            checks++;
            if (dev_data_o !== 32'h0) begin
                failures++;
                $display("FAIL data_idle_zero: dev_data_o=%h required 00000000", dev_data_o);
            end
        end
        if (rst_ni && !wb_cyc_o) begin
            checks++;
            if (wb_we_o !== 1'b0 || wb_sel_o !== 4'h0 || wb_dat_o !== 32'h0) begin
                failures++;
                $display("FAIL wb_idle_zero: we=%b sel=%h dat=%h required 0/0/0",
                         wb_we_o, wb_sel_o, wb_dat_o);
            end
        end
    end

    task automatic do_strobe(input logic [31:0] addr, input logic rw,
                             input logic [3:0] be, input logic [31:0] data);
        @(posedge clk_i);
        #1;
        dev_strobe_i      = 1'b1;
        dev_addr_i        = addr;
        dev_rw_i          = rw;
        dev_byte_enable_i = be;
        dev_data_i        = data;
        @(posedge clk_i);
        #1;
        dev_strobe_i      = 1'b0;
        dev_addr_i        = 32'h0;
        dev_rw_i          = 1'b0;
        dev_byte_enable_i = 4'h0;
        dev_data_i        = 32'h0;
    endtask

    task automatic wait_ready(input int bound, output bit seen, output logic [31:0] data);
        seen = 0;
        data = 32'h0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk_i);
            if (dev_data_ready_o) begin
                seen = 1;
                data = dev_data_o;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || dev_data_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: cyc=%b stb=%b ready=%b required 0/0/0",
                     wb_cyc_o, wb_stb_o, dev_data_ready_o);
        end
        checks++;
        if (bus_err_o !== 1'b0 || err_addr_o !== 32'h0 || wb_adr_o !== 32'h0
            || dev_data_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: bus_err=%b err_addr=%h adr=%h data=%h required zeros",
                     bus_err_o, err_addr_o, wb_adr_o, dev_data_o);
        end
        #1 rst_ni = 1'b1;
    endtask

    task automatic test_read_zero_wait();
        bit seen;
        logic [31:0] got;
        logic [31:0] exp;
        ack_en    = 1;
        ack_waits = 0;
        wb_dat_i  = 32'h1234_5678;
        exp_q.push_back(32'h1234_5678);
        do_strobe(32'hC000_0004, 1'b0, 4'hF, 32'h0);
        @(negedge clk_i);
        checks++;
        if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1 || wb_we_o !== 1'b0
            || wb_adr_o !== 32'hC000_0004) begin
            failures++;
            $display("FAIL rd_bus: cyc=%b stb=%b we=%b adr=%h required 1/1/0/c0000004",
                     wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o);
        end
        wait_ready(1, seen, got);
        exp = exp_q.pop_front();
        checks++;
        if (!seen || got !== exp || wb_cyc_o !== 1'b0) begin
            failures++;
            $display("FAIL rd_ready: seen=%0d data=%h cyc=%b required 1/%h/0",
                     seen, got, wb_cyc_o, exp);
        end
        @(negedge clk_i);
        checks++;
        if (dev_data_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL rd_pulse_width: ready=%b required 0", dev_data_ready_o);
        end
    endtask

    task automatic test_write_waits();
        bit seen;
        logic [31:0] got;
        logic [31:0] exp;
        int pulses;
        ack_en    = 1;
        ack_waits = 5;
        wb_dat_i  = 32'hFFFF_FFFF;
        exp_q.push_back(32'h0);
        do_strobe(32'hC000_0010, 1'b1, 4'b1100, 32'hA5A5_0000);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            checks++;
            if (wb_cyc_o !== 1'b1 || wb_we_o !== 1'b1 || wb_sel_o !== 4'b1100
                || wb_dat_o !== 32'hA5A5_0000 || wb_adr_o !== 32'hC000_0010) begin
                failures++;
                $display("FAIL wr_bus[%0d]: cyc=%b we=%b sel=%b dat=%h adr=%h required 1/1/1100/a5a50000/c0000010",
                         i, wb_cyc_o, wb_we_o, wb_sel_o, wb_dat_o, wb_adr_o);
            end
        end
        wait_ready(1, seen, got);
        exp = exp_q.pop_front();
        checks++;
        if (!seen || got !== exp) begin
            failures++;
            $display("FAIL wr_ready: seen=%0d data=%h required 1/%h", seen, got, exp);
        end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (dev_data_ready_o) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL wr_extra_ready: extra pulses=%0d required 0", pulses);
        end
    endtask

    task automatic test_timeout();
        int n;
        logic [31:0] exp;
        ack_en    = 0;
        wb_dat_i  = 32'h5555_AAAA;
        exp_q.push_back(32'h0);
        do_strobe(32'hC000_0100, 1'b0, 4'hF, 32'h0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (!wb_cyc_o) break;
            n++;
        end
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL to_cycles: bus cycles=%0d required 16", n);
        end
        exp = exp_q.pop_front();
        checks++;
        if (dev_data_ready_o !== 1'b1 || dev_data_o !== exp) begin
            failures++;
            $display("FAIL to_ready: ready=%b data=%h required 1/%h",
                     dev_data_ready_o, dev_data_o, exp);
        end
        checks++;
        if (bus_err_o !== 1'b1 || err_addr_o !== 32'hC000_0100) begin
            failures++;
            $display("FAIL to_err: bus_err=%b err_addr=%h required 1/c0000100",
                     bus_err_o, err_addr_o);
        end
    endtask

    task automatic test_err_overwrite();
        bit seen;
        logic [31:0] got;
        logic [31:0] exp;
        ack_en   = 0;
        err_en   = 1;
        wb_dat_i = 32'h7777_7777;
        exp_q.push_back(32'h0);
        do_strobe(32'hC0AB_0040, 1'b0, 4'hF, 32'h0);
        wait_ready(4, seen, got);
        exp = exp_q.pop_front();
        checks++;
        if (!seen || got !== exp) begin
            failures++;
            $display("FAIL err_ready: seen=%0d data=%h required 1/%h", seen, got, exp);
        end
        checks++;
        if (bus_err_o !== 1'b1 || err_addr_o !== 32'hC0AB_0040) begin
            failures++;
            $display("FAIL err_overwrite: bus_err=%b err_addr=%h required 1/c0ab0040",
                     bus_err_o, err_addr_o);
        end
        err_en = 0;
    endtask

    task automatic test_ack_err_priority();
        bit seen;
        logic [31:0] got;
        logic [31:0] exp;
        @(negedge clk_i);
        #1 rst_ni = 1'b0;
        #1 rst_ni = 1'b1;
        checks++;
        if (bus_err_o !== 1'b0 || err_addr_o !== 32'h0) begin
            failures++;
            $display("FAIL err_cleared: bus_err=%b err_addr=%h required 0/0",
                     bus_err_o, err_addr_o);
        end
        ack_en    = 1;
        ack_waits = 0;
        err_en    = 1;
        wb_dat_i  = 32'hDEAD_BEEF;
        exp_q.push_back(32'h0);
        do_strobe(32'hC000_0200, 1'b0, 4'hF, 32'h0);
        wait_ready(4, seen, got);
        exp = exp_q.pop_front();
        checks++;
        if (!seen || got !== exp || bus_err_o !== 1'b1 || err_addr_o !== 32'hC000_0200) begin
            failures++;
            $display("FAIL ack_err_prio: seen=%0d data=%h bus_err=%b err_addr=%h required 1/%h/1/c0000200",
                     seen, got, bus_err_o, err_addr_o, exp);
        end
        err_en = 0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        int pulses;
        int bad_adr;
        ack_en    = 1;
        ack_waits = 3;
        wb_dat_i  = 32'h0BAD_F00D;
        exp_q.push_back(32'h0BAD_F00D);
        do_strobe(32'hC000_0020, 1'b0, 4'hF, 32'h0);
        // Second request while the Wishbone cycle is in flight
        dev_strobe_i      = 1'b1;
        dev_addr_i        = 32'hC000_0FF0;
        dev_rw_i          = 1'b1;
        dev_byte_enable_i = 4'h1;
        dev_data_i        = 32'h1111_2222;
        @(posedge clk_i);
        #1;
        dev_strobe_i      = 1'b0;
        dev_addr_i        = 32'h0;
        dev_rw_i          = 1'b0;
        dev_byte_enable_i = 4'h0;
        dev_data_i        = 32'h0;
        pulses  = 0;
        bad_adr = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            if (wb_cyc_o && (wb_adr_o !== 32'hC000_0020 || wb_we_o !== 1'b0)) bad_adr++;
            if (dev_data_ready_o) begin
                pulses++;
                if (exp_q.size() > 0) begin
                    exp = exp_q.pop_front();
                    checks++;
                    if (dev_data_o !== exp) begin
                        failures++;
                        $display("FAIL b2b_data: data=%h required %h", dev_data_o, exp);
                    end
                end
            end
        end
        checks++;
        if (bad_adr != 0) begin
            failures++;
            $display("FAIL b2b_latch: corrupted bus cycles=%0d required 0", bad_adr);
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL b2b_pulses: ready pulses=%0d required 1", pulses);
        end
    endtask

    task automatic test_reset_mid_bus();
        bit seen;
        logic [31:0] got;
        logic [31:0] exp;
        ack_en = 0;
        do_strobe(32'hC000_0300, 1'b0, 4'hF, 32'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        checks++;
        if (wb_cyc_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre: cyc=%b required 1", wb_cyc_o);
        end
        #1 rst_ni = 1'b0;
        #1;
        checks++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || dev_data_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_async: cyc=%b stb=%b ready=%b required 0/0/0",
                     wb_cyc_o, wb_stb_o, dev_data_ready_o);
        end
        #1 rst_ni = 1'b1;
        ack_en    = 1;
        ack_waits = 1;
        wb_dat_i  = 32'hCAFE_0001;
        exp_q.push_back(32'hCAFE_0001);
        do_strobe(32'hC000_0304, 1'b0, 4'hF, 32'h0);
        wait_ready(4, seen, got);
        exp = exp_q.pop_front();
        checks++;
        if (!seen || got !== exp || bus_err_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_recover: seen=%0d data=%h bus_err=%b required 1/%h/0",
                     seen, got, bus_err_o, exp);
        end
    endtask

    initial begin
        rst_ni            = 1'b0;
        dev_strobe_i      = 1'b0;
        dev_addr_i        = 32'h0;
        dev_rw_i          = 1'b0;
        dev_byte_enable_i = 4'h0;
        dev_data_i        = 32'h0;
        wb_dat_i          = 32'h0;

        test_reset();
        test_read_zero_wait();
        test_write_waits();
        test_timeout();
        test_err_overwrite();
        test_ack_err_priority();
        test_back_to_back();
        test_reset_mid_bus();

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: leftover=%0d required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
